// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: 2-bit BHT branch predictor with EX-stage redirect and timed IF/ID flush
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fetch_pc              PC being fetched
//   fetch_pred_taken      combinational prediction for fetch_pc
//   ex_valid/jump/branch  EX instruction qualifiers
//   ex_cond, ex_pc        resolved branch condition and EX instruction PC
//   ex_pred_taken         prediction carried down from fetch
//   stall                 pipeline frozen this cycle
//   redirect              load a new PC this cycle
//   redirect_sel          0 = EX target, 1 = ex_pc+4 recovery
//   flush_f, flush_d      kill IF/ID and ID/EX contents
//   perf_branches, perf_mispredicts   event counters, present only with BRANCH_PERF_EN
module branch_redirect_ctrl #(
    parameter int INDEX_W      = 6,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc,
    output logic        fetch_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_jump,
    input  logic        ex_branch,
    input  logic        ex_cond,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic        stall,
    output logic        redirect,
    output logic        redirect_sel,
    output logic        flush_f,
    output logic        flush_d
`ifdef BRANCH_PERF_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
`endif
);
    typedef enum logic {RUN, FLUSH} state_t;
    localparam logic [1:0] FL_INIT = 2'(FLUSH_CYCLES - 2);
    state_t state, state_nx;
    logic [1:0] fl_cnt, fl_cnt_nx;
    logic [1:0] bht [2**INDEX_W];
    logic [INDEX_W-1:0] fidx, eidx;
    logic actual_taken, resolve, mispredict, bht_we, flush;
    logic [1:0] cur, nxt;
    logic unused;
    assign unused = ^{fetch_pc[31:INDEX_W+2], fetch_pc[1:0], ex_pc[31:INDEX_W+2], ex_pc[1:0]};
    assign fidx = fetch_pc[INDEX_W+1:2];
    assign eidx = ex_pc[INDEX_W+1:2];
    assign actual_taken = ex_jump | (ex_branch & ex_cond);
    assign resolve = ex_valid & !stall & (state == RUN);
    assign mispredict = resolve & (actual_taken != ex_pred_taken);
    assign bht_we = resolve & (ex_jump | ex_branch);
    assign cur = bht[eidx];
    assign nxt = actual_taken ? (cur == 2'b11 ? cur : cur + 2'd1) : (cur == 2'b00 ? cur : cur - 2'd1);
    // Entries reset to 2'b01, so bit 1 is already 0 during reset; the gate keeps it explicit.
    assign fetch_pred_taken = rst_n & bht[fidx][1];
    assign flush_f = flush;
    assign flush_d = flush;
    always_comb begin
        state_nx     = state;
        fl_cnt_nx    = fl_cnt;
        redirect     = 1'b0;
        redirect_sel = 1'b0;
        flush        = 1'b0;
        if (state == RUN) begin
            if (mispredict) begin
                redirect     = 1'b1;
                redirect_sel = !actual_taken;
                flush        = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_nx  = FLUSH;
                    fl_cnt_nx = FL_INIT;
                end
            end
        end else begin
            flush = 1'b1;
            if (!stall) begin
                if (fl_cnt == 2'd0) state_nx = RUN;
                else fl_cnt_nx = fl_cnt - 2'd1;
            end
        end
        // EX inputs can be live while reset is held; keep every output quiet.
        if (!rst_n) begin
            redirect     = 1'b0;
            redirect_sel = 1'b0;
            flush        = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            fl_cnt <= 2'd0;
        end else begin
            state  <= state_nx;
            fl_cnt <= fl_cnt_nx;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**INDEX_W; i++) bht[i] <= 2'b01;
        end else if (bht_we) begin
            bht[eidx] <= nxt;
        end
    end
`ifdef BRANCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches    <= 32'd0;
            perf_mispredicts <= 32'd0;
        end else begin
            if (bht_we) perf_branches <= perf_branches + 32'd1;
            if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: vector table, multi-cycle corner sequences and random model check
module tb_branch_redirect_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] fetch_pc = '0, ex_pc = '0;
    logic ex_valid = 0, ex_jump = 0, ex_branch = 0, ex_cond = 0, ex_pred_taken = 0, stall = 0;
    logic pt1, rd1, rs1, ff1, fd1;
    logic pt3, rd3, rs3, ff3, fd3;
    int n_chk = 0, n_fail = 0;
`ifdef BRANCH_PERF_EN
    logic [31:0] pb1, pm1, pb3, pm3;
`endif
    always #5 clk = ~clk;

    branch_redirect_ctrl dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .fetch_pred_taken(pt1),
        .ex_valid(ex_valid), .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_cond(ex_cond),
        .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .stall(stall),
        .redirect(rd1), .redirect_sel(rs1), .flush_f(ff1), .flush_d(fd1)
`ifdef BRANCH_PERF_EN
        , .perf_branches(pb1), .perf_mispredicts(pm1)
`endif
    );
    branch_redirect_ctrl #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .fetch_pred_taken(pt3),
        .ex_valid(ex_valid), .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_cond(ex_cond),
        .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .stall(stall),
        .redirect(rd3), .redirect_sel(rs3), .flush_f(ff3), .flush_d(fd3)
`ifdef BRANCH_PERF_EN
        , .perf_branches(pb3), .perf_mispredicts(pm3)
`endif
    );

    typedef struct {
        logic v, j, b, c;
        logic [31:0] epc;
        logic p, st;
        logic [31:0] fpc;
        logic e_pt, e_r, e_s, e_f;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, j, b, c, input logic [31:0] epc, input logic p, st,
                         input logic [31:0] fpc);
        @(negedge clk);
        ex_valid = v; ex_jump = j; ex_branch = b; ex_cond = c;
        ex_pc = epc; ex_pred_taken = p; stall = st; fetch_pc = fpc;
        #1;
    endtask

    task automatic chk1(input string tag, input logic e_pt, e_r, e_s, e_f);
        chk({tag, ".pred"}, 32'(pt1), 32'(e_pt));
        chk({tag, ".redirect"}, 32'(rd1), 32'(e_r));
        chk({tag, ".sel"}, 32'(rs1), 32'(e_s));
        chk({tag, ".flush_f"}, 32'(ff1), 32'(e_f));
        chk({tag, ".flush_d"}, 32'(fd1), 32'(e_f));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ex_valid = 1; ex_jump = 1; ex_branch = 0; ex_cond = 0; ex_pred_taken = 0; stall = 0;
        ex_pc = 32'h40; fetch_pc = 32'h40;
        #1;
        chk("rst.redirect", 32'(rd1), 0);
        chk("rst.flush", 32'(ff1 | fd1), 0);
        chk("rst.pred", 32'(pt1), 0);
        @(negedge clk);
        ex_valid = 0; ex_jump = 0;
        rst_n = 1'b1;
    endtask

    int bht_m[64];
    int unsigned m_br, m_mis;

    initial begin
        // {v,j,b,c,ex_pc,pred,stall,fetch_pc, exp pred,redirect,sel,flush}
        vt.push_back('{0,0,0,0,32'h00,0,0,32'h40, 0,0,0,0});
        vt.push_back('{1,0,1,1,32'h40,0,0,32'h40, 0,1,0,1});
        vt.push_back('{0,0,0,0,32'h00,0,0,32'h40, 1,0,0,0});
        vt.push_back('{1,0,1,1,32'h40,1,0,32'h40, 1,0,0,0});
        vt.push_back('{1,0,1,1,32'h40,1,0,32'h40, 1,0,0,0});
        vt.push_back('{1,0,1,1,32'h40,1,0,32'h40, 1,0,0,0});
        vt.push_back('{1,0,1,0,32'h40,1,0,32'h40, 1,1,1,1});
        vt.push_back('{0,0,0,0,32'h00,0,0,32'h40, 1,0,0,0});
        vt.push_back('{1,0,0,0,32'h80,1,0,32'h80, 0,1,1,1});
        vt.push_back('{0,0,0,0,32'h00,0,0,32'h80, 0,0,0,0});
        vt.push_back('{1,1,0,0,32'h80,1,0,32'h80, 0,0,0,0});
        vt.push_back('{0,0,0,0,32'h00,0,0,32'h80, 1,0,0,0});
        vt.push_back('{1,0,1,1,32'h44,0,1,32'h44, 0,0,0,0});
        vt.push_back('{1,0,1,1,32'h44,0,0,32'h44, 0,1,0,1});
        vt.push_back('{0,0,0,0,32'h00,0,0,32'h44, 1,0,0,0});
        vt.push_back('{1,0,1,0,32'h48,0,0,32'h48, 0,0,0,0});
        vt.push_back('{1,0,1,1,32'h48,0,0,32'h48, 0,1,0,1});
        vt.push_back('{0,0,0,0,32'h00,0,0,32'h48, 0,0,0,0});
        vt.push_back('{0,1,0,0,32'h4C,0,0,32'h4C, 0,0,0,0});
        vt.push_back('{0,0,0,0,32'h00,0,0,32'h4C, 0,0,0,0});

        do_reset();
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].v, vt[i].j, vt[i].b, vt[i].c, vt[i].epc, vt[i].p, vt[i].st, vt[i].fpc);
            chk1($sformatf("vec%0d", i), vt[i].e_pt, vt[i].e_r, vt[i].e_s, vt[i].e_f);
        end

        // Three-cycle flush stretched by a stall; wrong-path branch must be ignored.
        do_reset();
        drive(1,0,1,1,32'h40,0,0,32'h40);
        chk("fl3.c0.redirect", 32'(rd3), 1);
        chk("fl3.c0.flush", 32'(ff3 & fd3), 1);
        drive(1,0,1,1,32'h50,0,1,32'h40);
        chk("fl3.c1.redirect", 32'(rd3), 0);
        chk("fl3.c1.flush", 32'(ff3 & fd3), 1);
        drive(1,0,1,1,32'h50,0,0,32'h40);
        chk("fl3.c2.redirect", 32'(rd3), 0);
        chk("fl3.c2.flush", 32'(ff3 & fd3), 1);
        drive(1,0,1,1,32'h50,0,0,32'h40);
        chk("fl3.c3.redirect", 32'(rd3), 0);
        chk("fl3.c3.flush", 32'(ff3 & fd3), 1);
        drive(0,0,0,0,32'h0,0,0,32'h50);
        chk("fl3.c4.flush", 32'(ff3 | fd3), 0);
        chk("fl3.wrongpath_bht", 32'(pt3), 0);
        drive(0,0,0,0,32'h0,0,0,32'h40);
        chk("fl3.trained", 32'(pt3), 1);

        // Asynchronous reset in the middle of a flush.
        drive(1,0,1,1,32'h40,0,0,32'h40);
        chk("fl3.r.flush", 32'(ff3), 1);
        drive(0,0,0,0,32'h0,0,0,32'h40);
        chk("fl3.r.inflush", 32'(ff3), 1);
        rst_n = 1'b0;
        #1;
        chk("fl3.r.flush_f", 32'(ff3), 0);
        chk("fl3.r.flush_d", 32'(fd3), 0);
        chk("fl3.r.pred", 32'(pt3), 0);
`ifdef BRANCH_PERF_EN
        chk("fl3.r.perf_br", pb3, 0);
        chk("fl3.r.perf_mis", pm3, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against a per-entry counter model.
        do_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        m_br = 0; m_mis = 0;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] epc, fpc;
            logic v, j, b, c, p, st, act, mis;
            int ei;
            epc = $urandom & ~32'h000000E0;
            fpc = $urandom & ~32'h000000E0;
            v = $urandom_range(0, 3) != 0;
            j = $urandom_range(0, 5) == 0;
            b = !j && $urandom_range(0, 2) != 0;
            c = 1'($urandom);
            st = $urandom_range(0, 4) == 0;
            ei = int'(epc[7:2]);
            p = ($urandom_range(0, 3) == 0) ? 1'($urandom) : (bht_m[ei] >= 2);
            drive(v, j, b, c, epc, p, st, fpc);
            act = j | (b & c);
            mis = v & !st & (act != p);
            chk1($sformatf("rnd%0d", n), bht_m[int'(fpc[7:2])] >= 2, mis, mis & !act, mis);
            if (mis) m_mis++;
            if (v && !st && (j || b)) begin
                m_br++;
                bht_m[ei] = act ? ((bht_m[ei] < 3) ? bht_m[ei] + 1 : 3) : ((bht_m[ei] > 0) ? bht_m[ei] - 1 : 0);
            end
        end
`ifdef BRANCH_PERF_EN
        drive(0,0,0,0,32'h0,0,0,32'h0);
        chk("perf_branches", pb1, m_br);
        chk("perf_mispredicts", pm1, m_mis);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Fetch-side branch predictor plus EX-stage redirect/flush sequencer for the pipelined core.
- Fetch reads a 2-bit saturating-counter branch history table (BHT) indexed by the fetch PC.
- EX compares the resolved outcome (jump | branch & condition) with the prediction carried down the pipe, then issues a PC redirect and a timed flush of IF/ID on a mispredict.
- Trains the BHT on every resolved control-flow instruction.

Parameters:
- INDEX_W, 6: BHT index width; 2^INDEX_W entries indexed by pc[INDEX_W+1:2].
- FLUSH_CYCLES, 1: cycles flush_f/flush_d stay asserted per mispredict; legal range 1..4.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_pc  in  32  PC being fetched.
- fetch_pred_taken  out  1  prediction for fetch_pc, combinational = BHT[idx][1].
- ex_valid  in  1  EX holds a valid instruction.
- ex_jump  in  1  EX instruction is JAL/JALR.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_cond  in  1  resolved branch condition (already polarity-corrected).
- ex_pc  in  32  PC of the EX instruction.
- ex_pred_taken  in  1  prediction made at fetch, pipelined to EX.
- stall  in  1  pipeline frozen this cycle.
- redirect  out  1  load a new PC this cycle.
- redirect_sel  out  1  0 = EX computed target, 1 = ex_pc+4 recovery.
- flush_f  out  1  kill IF/ID register contents.
- flush_d  out  1  kill ID/EX register contents.

Behaviour:
- actual_taken = ex_jump | (ex_branch & ex_cond).
- resolve = ex_valid & !stall & state==RUN.
- mispredict = resolve & (actual_taken != ex_pred_taken). This includes non-control instructions predicted taken through aliasing.
- FSM states: RUN and FLUSH. A 2-bit counter fl_cnt tracks flush length.
- RUN:
  - If mispredict: redirect=1, flush_f=flush_d=1 in the same cycle (Mealy), and redirect_sel = !actual_taken.
  - If FLUSH_CYCLES>1, next state FLUSH with fl_cnt = FLUSH_CYCLES-2. Otherwise stay in RUN.
- FLUSH:
  - redirect=0; flush_f=flush_d=1.
  - EX inputs are ignored (wrong-path): no mispredict, no BHT update.
  - If !stall: when fl_cnt==0, go to RUN; else decrement fl_cnt.
  - If stall: hold state and fl_cnt, flushes stay asserted.
- Default outputs: redirect=0, redirect_sel=0, flush_f=0, flush_d=0.
- stall=1 in RUN: no redirect, no flush, no BHT update. The instruction resolves on the first non-stalled cycle.
- BHT update:
  - Occurs when resolve & (ex_jump | ex_branch). The entry at ex_pc[INDEX_W+1:2] is written at the clock edge.
  - Saturating increment if actual_taken, saturating decrement otherwise.
  - 2'b11 + taken stays at 2'b11; 2'b00 + not-taken stays at 2'b00.
  - Non-control instructions never update the BHT, even on an aliasing mispredict.
- Same-cycle read/write to the same index: fetch_pred_taken returns the pre-update value. The new value is visible the next cycle.
- Reset (asynchronous, any state including mid-FLUSH):
  - state=RUN, fl_cnt=0.
  - Every BHT entry = 2'b01 (weakly not-taken).
  - All outputs 0 while rst_n=0.
- Latency: prediction is 0 cycles (combinational). Redirect is 0 cycles after resolution. Training takes effect 1 cycle after resolution.

Optional Feature:
- Macro: BRANCH_PERF_EN.
- Defined: adds output ports perf_branches [31:0] and perf_mispredicts [31:0], reset to 0.
  - perf_branches increments on every BHT update.
  - perf_mispredicts increments on every mispredict.
  - Both wrap modulo 2^32 and both hold during stall.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then fetch_pc=0x40 -> fetch_pred_taken=0. Branch at ex_pc=0x40 taken, ex_pred_taken=0 -> redirect=1, redirect_sel=0, flush_f=flush_d=1 for one cycle. Next cycle, fetch_pc=0x40 -> fetch_pred_taken=1 (entry now 2'b10).
- Same branch taken 3 more times -> entry saturates at 2'b11. One not-taken with ex_pred_taken=1 -> redirect_sel=1, entry 2'b10, prediction still 1.
- FLUSH_CYCLES=3, mispredict, then stall=1 on the following cycle -> flushes held 4 cycles total. A valid EX branch during FLUSH is ignored (no redirect, BHT unchanged).
- Non-branch with ex_pred_taken=1 at ex_pc=0x80 -> redirect=1, redirect_sel=1, BHT[0x80 idx] unchanged. Correct prediction (taken/pred 1) -> redirect=0, no flush.
- rst_n low mid-FLUSH -> flush_f=flush_d=0 immediately, all entries back to 2'b01. With BRANCH_PERF_EN, both counters read 0.
- BRANCH_PERF_EN: 5 branches with 2 mispredicts -> perf_branches=5, perf_mispredicts=2. Preload perf_branches near 0xFFFFFFFF -> wraps to 0.
